// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-cycle data memory between the CPU load/store port and a
//   DMA engine. Each cycle at most one requester is granted and the access
//   completes in that same cycle (write commits at the clock edge, read data
//   comes combinationally from dm_rdata).
//
//   Arbitration: a locked DMA burst wins, then a DMA request that has waited
//   MAX_WAIT cycles, then the CPU, then an uncontested DMA request. A DMA burst
//   locks the memory until dma_last, a dropped dma_req, or MAX_BURST grants.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cpu_req/we/dm_w/dm_r/addr/wdata   CPU access request
//   cpu_ack, cpu_rdata, cpu_stall     CPU completion, read data, pipeline hold
//   dma_req/we/size/addr/wdata/last   DMA access request (size used for r and w)
//   dma_ack, dma_rdata                DMA completion and read data
//   dm_ena/w_ena/w/r/addr/wdata       memory-side command (all 0 when idle)
//   dm_rdata                          memory read data (combinational)
//   owner                             previous-cycle grant: 00 none, 01 CPU, 10 DMA
module dmem_arbiter #(
   parameter int MAX_WAIT  = 8,
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_dm_w,
   input  logic [1:0]  cpu_dm_r,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [1:0]  dma_size,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic        dma_last,
   output logic        dma_ack,
   output logic [31:0] dma_rdata,
   output logic        dm_ena,
   output logic        dm_w_ena,
   output logic [1:0]  dm_w,
   output logic [1:0]  dm_r,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   output logic [1:0]  owner
);

   localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

   logic               lock;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [BURST_W-1:0] burst_cnt;
   logic               grant_cpu;
   logic               grant_dma;
   logic [BURST_W-1:0] burst_inc;
   logic               burst_full;

   // Grant decision: purely combinational from requests and registered state.
   // Reset suppresses every grant so nothing reaches the memory that cycle.
   always_comb begin
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      if (!rst) begin
         if (dma_req && (lock || (wait_cnt == WAIT_MAX)))
            grant_dma = 1'b1;
         else if (cpu_req)
            grant_cpu = 1'b1;
         else if (dma_req)
            grant_dma = 1'b1;
      end
   end

   // Beat count this DMA grant would reach; an unlocked grant starts at 1.
   assign burst_inc  = burst_cnt + BURST_W'(1);
   assign burst_full = (burst_inc >= BURST_MAX);

   // Memory command mux; reads carry no write size and writes no read size.
   always_comb begin
      dm_ena   = 1'b0;
      dm_w_ena = 1'b0;
      dm_w     = 2'b00;
      dm_r     = 2'b00;
      dm_addr  = 32'd0;
      dm_wdata = 32'd0;
      if (grant_cpu) begin
         dm_ena   = 1'b1;
         dm_w_ena = cpu_we;
         dm_w     = cpu_we ? cpu_dm_w : 2'b00;
         dm_r     = cpu_we ? 2'b00 : cpu_dm_r;
         dm_addr  = cpu_addr;
         dm_wdata = cpu_wdata;
      end else if (grant_dma) begin
         dm_ena   = 1'b1;
         dm_w_ena = dma_we;
         dm_w     = dma_we ? dma_size : 2'b00;
         dm_r     = dma_we ? 2'b00 : dma_size;
         dm_addr  = dma_addr;
         dm_wdata = dma_wdata;
      end
   end

   assign cpu_ack   = grant_cpu;
   assign dma_ack   = grant_dma;
   assign cpu_rdata = grant_cpu ? dm_rdata : 32'd0;
   assign dma_rdata = grant_dma ? dm_rdata : 32'd0;
   assign cpu_stall = cpu_req & ~grant_cpu;

   // Arbitration state
   always_ff @(posedge clk) begin
      if (rst) begin
         lock      <= 1'b0;
         wait_cnt  <= '0;
         burst_cnt <= '0;
         owner     <= 2'b00;
      end else begin
         owner <= {grant_dma, grant_cpu};

         // Starvation counter: counts consecutive ungranted DMA request cycles.
         if (dma_req && !grant_dma) begin
            if (wait_cnt != WAIT_MAX)
               wait_cnt <= wait_cnt + WAIT_W'(1);
         end else begin
            wait_cnt <= '0;
         end

         if (grant_dma) begin
            if (dma_last || burst_full) begin
               lock      <= 1'b0;
               burst_cnt <= '0;
            end else begin
               lock      <= 1'b1;
               burst_cnt <= burst_inc;
            end
         end else if (lock) begin
            // A locked burst is always granted while dma_req holds, so being
            // locked without a grant means the engine abandoned the burst.
            lock      <= 1'b0;
            burst_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [1:0]  cpu_dm_w, cpu_dm_r;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_ack, cpu_stall;
   logic [31:0] cpu_rdata;
   logic        dma_req, dma_we, dma_last;
   logic [1:0]  dma_size;
   logic [31:0] dma_addr, dma_wdata;
   logic        dma_ack;
   logic [31:0] dma_rdata;
   logic        dm_ena, dm_w_ena;
   logic [1:0]  dm_w, dm_r;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [1:0]  owner;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_WAIT(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_dm_w(cpu_dm_w), .cpu_dm_r(cpu_dm_r),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_size(dma_size), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_last(dma_last),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .dm_ena(dm_ena), .dm_w_ena(dm_w_ena), .dm_w(dm_w), .dm_r(dm_r),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .owner(owner)
   );

   // Word-addressed memory model, combinational read, write at the edge.
   assign dm_rdata = mem[dm_addr[7:2]];
   always @(posedge clk) begin
      if (dm_ena && dm_w_ena)
         mem[dm_addr[7:2]] <= dm_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // g: 2'b01 CPU grant, 2'b10 DMA grant, 2'b00 none.
   task automatic grant_chk(input string tag, input logic [1:0] g);
      chk({tag, " ack"},   {30'd0, dma_ack, cpu_ack}, {30'd0, g});
      chk({tag, " stall"}, 32'(cpu_stall), 32'(cpu_req & ~g[0]));
      chk({tag, " ena"},   32'(dm_ena), 32'(|g));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic idle;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_dm_w = 2'b00; cpu_dm_r = 2'b00;
      cpu_addr = 32'd0; cpu_wdata = 32'd0;
      dma_req = 1'b0; dma_we = 1'b0; dma_size = 2'b00; dma_addr = 32'd0;
      dma_wdata = 32'd0; dma_last = 1'b0;
   endtask

   task automatic cpu_read(input logic [31:0] a);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_dm_w = 2'b00; cpu_dm_r = 2'b11;
      cpu_addr = a; cpu_wdata = 32'd0;
   endtask

   initial begin
      int beat;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      idle();
      rst = 1'b1;
      tick(); tick();

      // Reset: no grant, stall follows cpu_req, owner cleared.
      cpu_req = 1'b1;
      settle();
      grant_chk("reset", 2'b00);
      chk("reset owner", 32'(owner), 32'd0);
      chk("reset dm_addr", dm_addr, 32'd0);
      tick();
      rst = 1'b0;

      // CPU-only write then read back.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_dm_w = 2'b11; cpu_dm_r = 2'b00;
      cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      settle();
      grant_chk("cpu wr", 2'b01);
      chk("cpu wr w_ena", 32'(dm_w_ena), 32'd1);
      chk("cpu wr dm_w", 32'(dm_w), 32'd3);
      chk("cpu wr dm_r", 32'(dm_r), 32'd0);
      chk("cpu wr addr", dm_addr, 32'h10);
      exp_q.push_back(32'hDEADBEEF);
      tick();
      chk("owner cpu", 32'(owner), 32'd1);
      cpu_read(32'h10);
      settle();
      grant_chk("cpu rd", 2'b01);
      chk("cpu rd dm_w", 32'(dm_w), 32'd0);
      chk("cpu rd dm_r", 32'(dm_r), 32'd3);
      chk("cpu rd data", cpu_rdata, exp_q.pop_front());
      chk("cpu rd dma_rdata", dma_rdata, 32'd0);
      tick();

      idle();
      settle();
      grant_chk("idle", 2'b00);
      chk("idle dm_addr", dm_addr, 32'd0);
      tick();
      chk("owner none", 32'(owner), 32'd0);

      // Contention: 8 CPU grants, then a capped 4-beat DMA burst, then CPU.
      beat = 0;
      for (int c = 0; c < 13; c++) begin
         cpu_read(32'h10);
         dma_req = 1'b1; dma_we = 1'b1; dma_size = 2'b11; dma_last = 1'b0;
         dma_addr = 32'h20 + 32'(4 * beat);
         dma_wdata = 32'hCAFE0000 | 32'(beat);
         settle();
         if (c < 8 || c == 12) begin
            grant_chk($sformatf("contend c%0d", c), 2'b01);
            chk($sformatf("contend c%0d rdata", c), cpu_rdata, 32'hDEADBEEF);
         end else begin
            grant_chk($sformatf("burst c%0d", c), 2'b10);
            chk($sformatf("burst c%0d addr", c), dm_addr, 32'h20 + 32'(4 * beat));
            exp_q.push_back(32'hCAFE0000 | 32'(beat));
            beat++;
         end
         tick();
      end
      idle();
      for (int k = 0; k < 4; k++) begin
         cpu_read(32'h20 + 32'(4 * k));
         settle();
         chk($sformatf("burst readback %0d", k), cpu_rdata, exp_q.pop_front());
         tick();
      end
      idle();
      tick();

      // Burst ended early by dma_last on beat 2.
      dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b11; dma_addr = 32'h20; dma_last = 1'b0;
      settle();
      grant_chk("early b1", 2'b10);
      chk("early b1 rdata", dma_rdata, 32'hCAFE0000);
      chk("early b1 cpu_rdata", cpu_rdata, 32'd0);
      tick();
      dma_addr = 32'h24; dma_last = 1'b1;
      settle();
      grant_chk("early b2", 2'b10);
      chk("early b2 rdata", dma_rdata, 32'hCAFE0001);
      tick();
      chk("early lock", 32'(dut.lock), 32'd0);
      chk("early owner dma", 32'(owner), 32'd2);
      cpu_read(32'h10);
      dma_last = 1'b0;
      settle();
      grant_chk("early after", 2'b01);
      tick();
      chk("early owner cpu", 32'(owner), 32'd1);
      idle();
      tick();

      // Burst abort: dma_req drops while locked.
      dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b11; dma_addr = 32'h28;
      settle();
      grant_chk("abort b1", 2'b10);
      chk("abort b1 rdata", dma_rdata, 32'hCAFE0002);
      tick();
      chk("abort locked", 32'(dut.lock), 32'd1);
      dma_req = 1'b0;
      settle();
      grant_chk("abort drop", 2'b00);
      tick();
      chk("abort lock", 32'(dut.lock), 32'd0);
      chk("abort burst_cnt", 32'(dut.burst_cnt), 32'd0);
      cpu_read(32'h10);
      dma_req = 1'b1;
      settle();
      grant_chk("abort after", 2'b01);
      tick();
      idle();
      tick();

      // Reset during beat 2 of a burst.
      dma_req = 1'b1; dma_we = 1'b1; dma_size = 2'b11; dma_addr = 32'h40;
      dma_wdata = 32'h12345678; dma_last = 1'b0;
      settle();
      grant_chk("rstb b1", 2'b10);
      exp_q.push_back(32'h12345678);
      tick();
      rst = 1'b1;
      cpu_req = 1'b1;
      dma_addr = 32'h44; dma_wdata = 32'hBAD0BAD0;
      settle();
      grant_chk("rstb b2", 2'b00);
      chk("rstb w_ena", 32'(dm_w_ena), 32'd0);
      chk("rstb dma_rdata", dma_rdata, 32'd0);
      tick();
      chk("rstb owner", 32'(owner), 32'd0);
      chk("rstb lock", 32'(dut.lock), 32'd0);
      chk("rstb wait_cnt", 32'(dut.wait_cnt), 32'd0);
      rst = 1'b0;
      idle();
      cpu_read(32'h44);
      settle();
      chk("rstb no commit", cpu_rdata, 32'd0);
      tick();
      idle();
      dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b11; dma_addr = 32'h40; dma_last = 1'b1;
      settle();
      grant_chk("rstb dma rd", 2'b10);
      chk("rstb dma rdata", dma_rdata, exp_q.pop_front());
      tick();
      idle();
      chk("queue drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
